// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - round-robin arbiter with registered index and 2:4 decoded one-hot grant
// Optional grant timeout compiled in with `define ARB_TIMEOUT_EN (HOLD_MAX bounds grant length).
module rr_decode_arbiter #(
    parameter int HOLD_MAX = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] gnt_idx,
    output logic       gnt_vld,
    output logic       timeout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    if (HOLD_MAX < 2) begin : g_bad_hold_max
        $error("rr_decode_arbiter: HOLD_MAX must be >= 2");
    end

    state_t     state_q, state_d;
    logic [1:0] ptr_q, ptr_d;
    logic [1:0] gnt_idx_q, gnt_idx_d;
    logic       gnt_vld_q, gnt_vld_d;
    logic [1:0] pick;
    logic [1:0] cand;
    logic       hold_expired;

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    assign hold_expired = (cnt_q == CNT_LAST);
    assign timeout      = timeout_q;

    // Cleared while idle so every new grant starts counting from zero.
    always_comb begin
        cnt_d     = cnt_q;
        timeout_d = 1'b0;
        if (state_q == IDLE) begin
            cnt_d = '0;
        end else if (state_q == BUSY) begin
            if (cnt_q != CNT_LAST) begin
                cnt_d = cnt_q + 1'b1;
            end
            timeout_d = req[gnt_idx_q] & hold_expired;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end
`else
    assign hold_expired = 1'b0;
    assign timeout      = 1'b0;
`endif

    // Walk from ptr+3 down to ptr so the requester closest to ptr wins.
    always_comb begin
        pick = ptr_q;
        cand = ptr_q;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                pick = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        gnt_idx_d = gnt_idx_q;
        gnt_vld_d = gnt_vld_q;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    gnt_idx_d = pick;
                    gnt_vld_d = 1'b1;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                if (!req[gnt_idx_q] || hold_expired) begin
                    gnt_vld_d = 1'b0;
                    ptr_d     = gnt_idx_q + 2'd1;
                    state_d   = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d   = IDLE;
                gnt_vld_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= 2'd0;
            gnt_idx_q <= 2'd0;
            gnt_vld_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            gnt_idx_q <= gnt_idx_d;
            gnt_vld_q <= gnt_vld_d;
        end
    end

    // Grant is a pure decode of registered state, never of req.
    always_comb begin
        gnt            = 4'b0000;
        gnt[gnt_idx_q] = gnt_vld_q;
    end

    assign gnt_idx = gnt_idx_q;
    assign gnt_vld = gnt_vld_q;

endmodule
